alu_fifo_param: RTL and testbench

- Parametrised synchronous FIFO with ack/err handshakes, used as the instruction, operand and result buffers between the ALU slave register block and the ALU execution FSM.
- Replaces the fixed 8x32 FIFO generation with configurable width, depth and programmable almost-full/almost-empty thresholds.
- Adds a synchronous flush, an occupancy count and sticky overflow/underflow flags for the ALU_STATUS register.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_fifo_param_if.sv | 39 +++
 rtl/alu_fifo_ram.sv | 39 +++
 rtl/alu_fifo_param.sv | 105 ++++++++++
 tb/tb_alu_fifo_param.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and width helper for the ALU FIFO slice
package alu_pkg;

    localparam int ALU_DATA_W     = 32;
    localparam int ALU_FIFO_DEPTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_fifo_param_if.sv
// rtl/alu_fifo_param_if.sv - FIFO request/response bundle with driver and FIFO views
interface alu_fifo_param_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEPTH  = ALU_FIFO_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic              clear;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              ovf_sticky;
    logic              unf_sticky;

    modport master (
        output clear, wr_en, din, rd_en,
        input  dout, wr_ack, wr_err, rd_ack, rd_err, full, empty,
               almost_full, almost_empty, count, ovf_sticky, unf_sticky
    );

    modport slave (
        input  clear, wr_en, din, rd_en,
        output dout, wr_ack, wr_err, rd_ack, rd_err, full, empty,
               almost_full, almost_empty, count, ovf_sticky, unf_sticky
    );

endinterface

// File: rtl/alu_fifo_ram.sv
// rtl/alu_fifo_ram.sv - DEPTH x DATA_W storage, one write port, one registered read port
module alu_fifo_ram
    import alu_pkg::*;
#(
    parameter int  DATA_W = ALU_DATA_W,
    parameter int  DEPTH  = ALU_FIFO_DEPTH,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    input  logic              rclr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alu_fifo_param.sv
// rtl/alu_fifo_param.sv - parametrised FIFO with ack/err pulses, thresholds, flush and sticky flags
module alu_fifo_param
    import alu_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int DEPTH     = ALU_FIFO_DEPTH,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_fifo_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full_c;
    logic          empty_c;
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_rej;
    logic          rd_rej;
    logic [DATA_W-1:0] rdata;

    assign full_c  = (count_q == DEPTH_C);
    assign empty_c = (count_q == '0);

    // Full/empty are judged on start-of-cycle occupancy; clear masks both requests.
    assign wr_ok  = bus.wr_en && !full_c  && !bus.clear;
    assign rd_ok  = bus.rd_en && !empty_c && !bus.clear;
    assign wr_rej = bus.wr_en &&  full_c  && !bus.clear;
    assign rd_rej = bus.rd_en &&  empty_c && !bus.clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            bus.wr_ack     <= 1'b0;
            bus.wr_err     <= 1'b0;
            bus.rd_ack     <= 1'b0;
            bus.rd_err     <= 1'b0;
            bus.ovf_sticky <= 1'b0;
            bus.unf_sticky <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            bus.wr_ack     <= 1'b0;
            bus.wr_err     <= 1'b0;
            bus.rd_ack     <= 1'b0;
            bus.rd_err     <= 1'b0;
            bus.ovf_sticky <= 1'b0;
            bus.unf_sticky <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CW'(1);
            end
            bus.wr_ack     <= wr_ok;
            bus.wr_err     <= wr_rej;
            bus.rd_ack     <= rd_ok;
            bus.rd_err     <= rd_rej;
            bus.ovf_sticky <= bus.ovf_sticky | wr_rej;
            bus.unf_sticky <= bus.unf_sticky | rd_rej;
        end
    end

    alu_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_ok),
        .waddr   (wr_ptr),
        .wdata   (bus.din),
        .re      (rd_ok),
        .raddr   (rd_ptr),
        .rclr    (bus.clear),
        .rdata   (rdata)
    );

    assign bus.dout         = rdata;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);

endmodule

// File: tb/tb_alu_fifo_param.sv
// tb/tb_alu_fifo_param.sv - self-checking bench for alu_fifo_param against a queue model
module tb_alu_fifo_param;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int AFT = 6;
    localparam int AET = 1;

    logic clk;
    logic reset_n;
    logic checking;
    int   n_pass;
    int   n_total;

    alu_fifo_param_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

    alu_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AFULL_TH  (AFT),
        .AEMPTY_TH (AET)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue plus the last handshake outcome.
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_dout;
    logic m_wr_ack, m_wr_err, m_rd_ack, m_rd_err, m_ovf, m_unf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_dout = '0;
            {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err, m_ovf, m_unf} = '0;
        end else if (bus.clear) begin
            m_q.delete();
            m_dout = '0;
            {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err, m_ovf, m_unf} = '0;
        end else begin
            automatic bit was_full  = (m_q.size() == DEP);
            automatic bit was_empty = (m_q.size() == 0);
            m_rd_ack = bus.rd_en && !was_empty;
            m_rd_err = bus.rd_en && was_empty;
            m_wr_ack = bus.wr_en && !was_full;
            m_wr_err = bus.wr_en && was_full;
            if (m_rd_ack) m_dout = m_q.pop_front();
            if (m_wr_ack) m_q.push_back(bus.din);
            m_ovf = m_ovf | m_wr_err;
            m_unf = m_unf | m_rd_err;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("count",        64'(bus.count),        64'(m_q.size()));
            chk("full",         64'(bus.full),         64'(m_q.size() == DEP));
            chk("empty",        64'(bus.empty),        64'(m_q.size() == 0));
            chk("almost_full",  64'(bus.almost_full),  64'(m_q.size() >= AFT));
            chk("almost_empty", 64'(bus.almost_empty), 64'(m_q.size() <= AET));
            chk("dout",         64'(bus.dout),         64'(m_dout));
            chk("wr_ack",       64'(bus.wr_ack),       64'(m_wr_ack));
            chk("wr_err",       64'(bus.wr_err),       64'(m_wr_err));
            chk("rd_ack",       64'(bus.rd_ack),       64'(m_rd_ack));
            chk("rd_err",       64'(bus.rd_err),       64'(m_rd_err));
            chk("ovf_sticky",   64'(bus.ovf_sticky),   64'(m_ovf));
            chk("unf_sticky",   64'(bus.unf_sticky),   64'(m_unf));
        end
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bus.wr_en = w;
        bus.din   = d;
        bus.rd_en = r;
        bus.clear = c;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        checking = 1'b0;
        reset_n  = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
        bus.din   = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checking = 1'b1;

        chk("rst_empty",        64'(bus.empty),        64'd1);
        chk("rst_almost_empty", 64'(bus.almost_empty), 64'd1);
        chk("rst_count",        64'(bus.count),        64'd0);
        chk("rst_dout",         64'(bus.dout),         64'd0);
        chk("rst_handshakes",   64'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 64'd0);

        for (int i = 0; i < DEP; i++) begin
            step(1'b1, DW'(32'h11 * (i + 1)), 1'b0, 1'b0);
            chk("fill_wr_ack", 64'(bus.wr_ack),      64'd1);
            chk("fill_afull",  64'(bus.almost_full), 64'(i + 1 >= 6));
        end
        chk("fill_full", 64'(bus.full), 64'd1);
        step(1'b1, 32'h99, 1'b0, 1'b0);
        chk("ovf_wr_err", 64'(bus.wr_err),     64'd1);
        chk("ovf_sticky", 64'(bus.ovf_sticky), 64'd1);
        chk("ovf_count",  64'(bus.count),      64'd8);

        for (int i = 0; i < DEP; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_dout",   64'(bus.dout),   64'(32'h11 * (i + 1)));
            chk("drain_rd_ack", 64'(bus.rd_ack), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf_rd_err", 64'(bus.rd_err),     64'd1);
        chk("unf_sticky", 64'(bus.unf_sticky), 64'd1);
        chk("unf_dout",   64'(bus.dout),       64'h88);

        for (int i = 0; i < DEP; i++) step(1'b1, DW'(32'h20 + i), 1'b0, 1'b0);
        step(1'b1, 32'hAA, 1'b1, 1'b0);
        chk("sim_full_rd_ack", 64'(bus.rd_ack), 64'd1);
        chk("sim_full_wr_err", 64'(bus.wr_err), 64'd1);
        chk("sim_full_count",  64'(bus.count),  64'd7);
        for (int i = 0; i < DEP - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'hBB, 1'b1, 1'b0);
        chk("sim_empty_wr_ack", 64'(bus.wr_ack), 64'd1);
        chk("sim_empty_rd_err", 64'(bus.rd_err), 64'd1);
        chk("sim_empty_count",  64'(bus.count),  64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("sim_empty_data", 64'(bus.dout), 64'hBB);

        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h31 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(32'h40 + i), 1'b1, 1'b0);
            chk("wrap_count", 64'(bus.count), 64'd3);
            chk("wrap_data",  64'(bus.dout),  (i < 3) ? 64'(32'h31 + i) : 64'(32'h40 + i - 3));
        end

        step(1'b1, 32'h51, 1'b0, 1'b0);
        step(1'b1, 32'h52, 1'b0, 1'b0);
        chk("pre_clear_count", 64'(bus.count), 64'd5);
        step(1'b1, 32'h55, 1'b0, 1'b1);
        chk("clear_count",  64'(bus.count),  64'd0);
        chk("clear_wr_ack", 64'(bus.wr_ack), 64'd0);
        chk("clear_sticky", 64'({bus.ovf_sticky, bus.unf_sticky}), 64'd0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h5A, 1'b0, 1'b0);
        step(1'b1, 32'h6B, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_dout",  64'(bus.dout),  64'h5A);
        chk("pre_rst_count", 64'(bus.count), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_dout",  64'(bus.dout),  64'd0);
        chk("async_rst_count", 64'(bus.count), 64'd0);
        chk("async_rst_empty", 64'(bus.empty), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
